// File: rtl/wb_write_arb_if.sv
// Writeback arbiter bus: main-pipeline and multicycle-unit write requests,
// the registered register-file write port and the decode-stage pending lookup.
interface wb_write_arb_if;
    logic        pipe_valid;
    logic [4:0]  pipe_dst;
    logic [31:0] pipe_result;
    logic        md_valid;
    logic [4:0]  md_dst;
    logic [31:0] md_result;
    logic        md_ready;
    logic [4:0]  WB_Dst;
    logic [31:0] WB_Result;
    logic        RFWr;
    logic [4:0]  ID_rs;
    logic [4:0]  ID_rt;
    logic        pend_rs;
    logic        pend_rt;

    // The arbiter itself
    modport slave (
        input  pipe_valid, pipe_dst, pipe_result,
        input  md_valid, md_dst, md_result,
        output md_ready,
        output WB_Dst, WB_Result, RFWr,
        input  ID_rs, ID_rt,
        output pend_rs, pend_rt
    );

    // The pipeline / multicycle unit / decode side
    modport master (
        output pipe_valid, pipe_dst, pipe_result,
        output md_valid, md_dst, md_result,
        input  md_ready,
        input  WB_Dst, WB_Result, RFWr,
        output ID_rs, ID_rt,
        input  pend_rs, pend_rt
    );
endinterface

// File: rtl/wb_write_arb.sv
// Register-file writeback arbiter. Main-pipeline writes always win; results
// from the multicycle (mul/div) unit wait in a small FIFO and drain on idle
// cycles. A pipe write to the same register kills any older buffered result
// for it, and the pend_* outputs tell decode which sources are still in flight.
module wb_write_arb #(
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    wb_write_arb_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);

    logic [4:0]       fifo_dst [DEPTH];
    logic [31:0]      fifo_res [DEPTH];
    logic [DEPTH-1:0] fifo_live;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    logic        rf_wr;
    logic [4:0]  wb_dst;
    logic [31:0] wb_result;

    logic pipe_req;
    logic enq;
    logic pop;
    logic pend_rs;
    logic pend_rt;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign pipe_req     = bus.pipe_valid && (bus.pipe_dst != 5'd0);
    assign bus.md_ready = (count < FULL);
    assign enq          = bus.md_valid && bus.md_ready && (bus.md_dst != 5'd0);
    assign pop          = !pipe_req && (count != '0);

    assign bus.RFWr      = rf_wr;
    assign bus.WB_Dst    = wb_dst;
    assign bus.WB_Result = wb_result;
    assign bus.pend_rs   = pend_rs;
    assign bus.pend_rt   = pend_rt;

    // FIFO payload storage; validity is tracked by count and live bits, so no reset needed
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_dst[wr_ptr] <= bus.md_dst;
            fifo_res[wr_ptr] <= bus.md_result;
        end
    end

    // Live bits: squashed by a younger pipe write, cleared on pop, set on enqueue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_live <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pipe_req && (fifo_dst[i] == bus.pipe_dst)) begin
                    fifo_live[i] <= 1'b0;
                end
            end
            if (pop) begin
                fifo_live[rd_ptr] <= 1'b0;
            end
            if (enq) begin
                fifo_live[wr_ptr] <= 1'b1;
            end
        end
    end

    // Circular pointers and occupancy count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({enq, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered write port: pipe first, then FIFO head, otherwise idle with data held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_wr     <= 1'b0;
            wb_dst    <= 5'd0;
            wb_result <= 32'd0;
        end else if (pipe_req) begin
            rf_wr     <= 1'b1;
            wb_dst    <= bus.pipe_dst;
            wb_result <= bus.pipe_result;
        end else if (pop) begin
            rf_wr     <= fifo_live[rd_ptr];
            wb_dst    <= fifo_dst[rd_ptr];
            wb_result <= fifo_res[rd_ptr];
        end else begin
            rf_wr     <= 1'b0;
        end
    end

    // Decode hazard lookup against live buffered entries and the write in progress
    always_comb begin
        pend_rs = 1'b0;
        pend_rt = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_live[i] && (fifo_dst[i] == bus.ID_rs)) pend_rs = 1'b1;
            if (fifo_live[i] && (fifo_dst[i] == bus.ID_rt)) pend_rt = 1'b1;
        end
        if (rf_wr && (wb_dst == bus.ID_rs)) pend_rs = 1'b1;
        if (rf_wr && (wb_dst == bus.ID_rt)) pend_rt = 1'b1;
        if (bus.ID_rs == 5'd0) pend_rs = 1'b0;
        if (bus.ID_rt == 5'd0) pend_rt = 1'b0;
    end
endmodule

// File: tb/tb_wb_write_arb.sv
// Self-checking bench for wb_write_arb: a behavioural reference model queues
// expected register-file writes at each sampling edge, and a negedge monitor
// pops and compares them; scenario tasks add targeted inline checks.
module tb_wb_write_arb;
    localparam int DEPTH = 2;

    typedef struct {
        logic [4:0]  dst;
        logic [31:0] res;
        logic        live;
    } ent_t;

    typedef struct {
        logic [4:0]  dst;
        logic [31:0] res;
    } wr_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    ent_t mq[$];
    wr_t  exp_q[$];
    logic exp_write = 1'b0;
    logic exp_ready = 1'b1;
    ent_t popped;
    wr_t  got;

    wb_write_arb_if bus ();

    wb_write_arb #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: decides what the next edge must write and updates the FIFO model
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            exp_q.delete();
            exp_write = 1'b0;
            exp_ready = 1'b1;
        end else begin
            exp_write = 1'b0;
            exp_ready = (mq.size() < DEPTH);
            if (bus.pipe_valid && bus.pipe_dst != 5'd0) begin
                foreach (mq[i]) begin
                    if (mq[i].dst == bus.pipe_dst) mq[i].live = 1'b0;
                end
                exp_q.push_back('{dst: bus.pipe_dst, res: bus.pipe_result});
                exp_write = 1'b1;
            end else if (mq.size() > 0) begin
                popped = mq.pop_front();
                if (popped.live) begin
                    exp_q.push_back('{dst: popped.dst, res: popped.res});
                    exp_write = 1'b1;
                end
            end
            if (bus.md_valid && exp_ready && bus.md_dst != 5'd0) begin
                mq.push_back('{dst: bus.md_dst, res: bus.md_result, live: 1'b1});
            end
            exp_ready = (mq.size() < DEPTH);
        end
    end

    // Scoreboard monitor: compares every cycle's write port and md_ready against the model
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (bus.RFWr !== exp_write) begin
                failures++;
                $display("[TB] FAIL sb_rfwr: got %b want %b at %0t", bus.RFWr, exp_write, $time);
            end
            checks++;
            if (bus.md_ready !== exp_ready) begin
                failures++;
                $display("[TB] FAIL sb_md_ready: got %b want %b at %0t", bus.md_ready, exp_ready, $time);
            end
            if (exp_write && exp_q.size() > 0) begin
                got = exp_q.pop_front();
                checks++;
                if (bus.WB_Dst !== got.dst || bus.WB_Result !== got.res) begin
                    failures++;
                    $display("[TB] FAIL sb_write: got dst=%0d res=%h want dst=%0d res=%h at %0t",
                             bus.WB_Dst, bus.WB_Result, got.dst, got.res, $time);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pipe_valid  = 1'b0;
        bus.pipe_dst    = 5'd0;
        bus.pipe_result = 32'd0;
        bus.md_valid    = 1'b0;
        bus.md_dst      = 5'd0;
        bus.md_result   = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        bus.ID_rs = 5'd5;
        bus.ID_rt = 5'd7;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.RFWr !== 1'b0 || bus.WB_Dst !== 5'd0 || bus.WB_Result !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_port: got rfwr=%b dst=%0d res=%h want 0/0/0", bus.RFWr, bus.WB_Dst, bus.WB_Result);
        end
        checks++;
        if (bus.md_ready !== 1'b1 || bus.pend_rs !== 1'b0 || bus.pend_rt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: got ready=%b rs=%b rt=%b want 1/0/0", bus.md_ready, bus.pend_rs, bus.pend_rt);
        end
        #2 rst = 1'b1;
    endtask

    task automatic test_pipe_only();
        step();
        bus.pipe_valid = 1'b1; bus.pipe_dst = 5'd5; bus.pipe_result = 32'h1234;
        step();
        bus.pipe_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.RFWr !== 1'b1 || bus.WB_Dst !== 5'd5 || bus.WB_Result !== 32'h1234) begin
            failures++;
            $display("[TB] FAIL pipe_write: got rfwr=%b dst=%0d res=%h want 1/5/1234", bus.RFWr, bus.WB_Dst, bus.WB_Result);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.RFWr !== 1'b0 || bus.WB_Dst !== 5'd5) begin
            failures++;
            $display("[TB] FAIL pipe_idle: got rfwr=%b dst=%0d want 0/5", bus.RFWr, bus.WB_Dst);
        end
    endtask

    task automatic test_md_latency();
        step();
        bus.md_valid = 1'b1; bus.md_dst = 5'd7; bus.md_result = 32'hAAAA;
        bus.ID_rs = 5'd7; bus.ID_rt = 5'd3;
        @(negedge clk);
        checks++;
        if (bus.pend_rs !== 1'b0) begin
            failures++;
            $display("[TB] FAIL md_pend_early: got %b want 0", bus.pend_rs);
        end
        step();
        bus.md_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.pend_rs !== 1'b1 || bus.pend_rt !== 1'b0 || bus.RFWr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL md_buffered: got rs=%b rt=%b rfwr=%b want 1/0/0", bus.pend_rs, bus.pend_rt, bus.RFWr);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.RFWr !== 1'b1 || bus.WB_Dst !== 5'd7 || bus.WB_Result !== 32'hAAAA || bus.pend_rs !== 1'b1) begin
            failures++;
            $display("[TB] FAIL md_write: got rfwr=%b dst=%0d res=%h rs=%b want 1/7/aaaa/1",
                     bus.RFWr, bus.WB_Dst, bus.WB_Result, bus.pend_rs);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.pend_rs !== 1'b0 || bus.RFWr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL md_pend_fall: got rs=%b rfwr=%b want 0/0", bus.pend_rs, bus.RFWr);
        end
    endtask

    task automatic test_priority_fill();
        logic [4:0] want_dst[7];
        logic       want_ready[7];
        want_dst   = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd10, 5'd11, 5'd11};
        want_ready = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bus.ID_rs = 5'd0; bus.ID_rt = 5'd0;
        step();
        for (int i = 0; i < 7; i++) begin
            bus.pipe_valid  = (i < 4);
            bus.pipe_dst    = 5'(i + 1);
            bus.pipe_result = 32'h100 + 32'(i);
            bus.md_valid    = (i < 4);
            bus.md_dst      = (i < 2) ? 5'(10 + i) : 5'd12;
            bus.md_result   = 32'hA0 + 32'(bus.md_dst);
            if (i > 0) begin
                @(negedge clk);
                checks++;
                if (bus.WB_Dst !== want_dst[i-1] || bus.md_ready !== want_ready[i-1]) begin
                    failures++;
                    $display("[TB] FAIL fill_%0d: got dst=%0d ready=%b want %0d/%b",
                             i, bus.WB_Dst, bus.md_ready, want_dst[i-1], want_ready[i-1]);
                end
            end
            step();
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus.RFWr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fill_drained: got rfwr=%b want 0", bus.RFWr);
        end
    endtask

    task automatic test_squash();
        step();
        bus.pipe_valid = 1'b1; bus.pipe_dst = 5'd2; bus.pipe_result = 32'h22;
        bus.md_valid = 1'b1; bus.md_dst = 5'd9; bus.md_result = 32'h99;
        bus.ID_rs = 5'd9;
        step();
        bus.pipe_dst = 5'd9; bus.pipe_result = 32'h1;
        bus.md_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.pend_rs !== 1'b1) begin
            failures++;
            $display("[TB] FAIL squash_pend: got %b want 1", bus.pend_rs);
        end
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus.RFWr !== 1'b1 || bus.WB_Dst !== 5'd9 || bus.WB_Result !== 32'h1) begin
            failures++;
            $display("[TB] FAIL squash_pipe: got rfwr=%b dst=%0d res=%h want 1/9/1", bus.RFWr, bus.WB_Dst, bus.WB_Result);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.RFWr !== 1'b0 || bus.pend_rs !== 1'b0 || bus.md_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL squash_pop: got rfwr=%b rs=%b ready=%b want 0/0/1", bus.RFWr, bus.pend_rs, bus.md_ready);
        end
    endtask

    task automatic test_dst_zero();
        step();
        bus.pipe_valid = 1'b1; bus.pipe_dst = 5'd0; bus.pipe_result = 32'h55;
        bus.md_valid = 1'b1; bus.md_dst = 5'd0; bus.md_result = 32'h66;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            checks++;
            if (bus.RFWr !== 1'b0 || bus.md_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL dst_zero_%0d: got rfwr=%b ready=%b want 0/1", i, bus.RFWr, bus.md_ready);
            end
        end
        idle_inputs();
        step();
        @(negedge clk);
        checks++;
        if (bus.RFWr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL dst_zero_after: got rfwr=%b want 0", bus.RFWr);
        end
    endtask

    task automatic test_back_to_back();
        step();
        bus.md_valid = 1'b1; bus.md_dst = 5'd20; bus.md_result = 32'h2020;
        bus.ID_rs = 5'd0; bus.ID_rt = 5'd21;
        step();
        bus.md_dst = 5'd21; bus.md_result = 32'h2121;
        @(negedge clk);
        checks++;
        if (bus.md_ready !== 1'b1 || bus.pend_rt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_first: got ready=%b rt=%b want 1/0", bus.md_ready, bus.pend_rt);
        end
        step();
        bus.md_dst = 5'd22; bus.md_result = 32'h2222;
        @(negedge clk);
        checks++;
        if (bus.md_ready !== 1'b1 || bus.WB_Dst !== 5'd20 || bus.pend_rt !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_mid: got ready=%b dst=%0d rt=%b want 1/20/1", bus.md_ready, bus.WB_Dst, bus.pend_rt);
        end
        step();
        bus.md_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.md_ready !== 1'b1 || bus.WB_Dst !== 5'd21 || bus.WB_Result !== 32'h2121) begin
            failures++;
            $display("[TB] FAIL b2b_second: got ready=%b dst=%0d res=%h want 1/21/2121", bus.md_ready, bus.WB_Dst, bus.WB_Result);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.RFWr !== 1'b1 || bus.WB_Dst !== 5'd22) begin
            failures++;
            $display("[TB] FAIL b2b_third: got rfwr=%b dst=%0d want 1/22", bus.RFWr, bus.WB_Dst);
        end
        step();
    endtask

    task automatic test_reset_mid();
        step();
        bus.pipe_valid = 1'b1; bus.pipe_dst = 5'd1; bus.pipe_result = 32'h11;
        bus.md_valid = 1'b1; bus.md_dst = 5'd30; bus.md_result = 32'h3030;
        bus.ID_rs = 5'd30; bus.ID_rt = 5'd31;
        step();
        bus.pipe_dst = 5'd2;
        bus.md_dst = 5'd31; bus.md_result = 32'h3131;
        step();
        idle_inputs();
        checks++;
        if (bus.pend_rs !== 1'b1 || bus.pend_rt !== 1'b1 || bus.md_ready !== 1'b0 || bus.RFWr !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rstmid_full: got rs=%b rt=%b ready=%b rfwr=%b want 1/1/0/1",
                     bus.pend_rs, bus.pend_rt, bus.md_ready, bus.RFWr);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (bus.RFWr !== 1'b0 || bus.md_ready !== 1'b1 || bus.pend_rs !== 1'b0 || bus.pend_rt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_async: got rfwr=%b ready=%b rs=%b rt=%b want 0/1/0/0",
                     bus.RFWr, bus.md_ready, bus.pend_rs, bus.pend_rt);
        end
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            checks++;
            if (bus.RFWr !== 1'b0 || bus.pend_rs !== 1'b0 || bus.pend_rt !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rstmid_after_%0d: got rfwr=%b rs=%b rt=%b want 0/0/0",
                         i, bus.RFWr, bus.pend_rs, bus.pend_rt);
            end
        end
    endtask

    // Scenario sequence
    initial begin
        $display("[TB] wb_write_arb bench start");
        test_reset();
        test_pipe_only();
        test_md_latency();
        test_priority_fill();
        test_squash();
        test_dst_zero();
        test_back_to_back();
        test_reset_mid();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
